// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bus: pipeline WB request, LU valid/ready result, RF write and hazard outputs.
interface wb_write_arbiter_if #(parameter int XLEN = 32);
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            lu_valid;
   logic [4:0]      lu_rd;
   logic [XLEN-1:0] lu_data;
   logic            lu_ready;
   logic            rf_we;
   logic [4:0]      rf_a3;
   logic [XLEN-1:0] rf_wd;
   logic [31:0]     pend_mask;
   logic            err_conflict;

   modport slave (
      input  wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
      output lu_ready, rf_we, rf_a3, rf_wd, pend_mask, err_conflict
   );

   modport master (
      output wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
      input  lu_ready, rf_we, rf_a3, rf_wd, pend_mask, err_conflict
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, LU results queue in a FIFO.
// Optional WB_BYPASS_EN lets an LU result go straight to the port when FIFO empty and WB idle.
module wb_write_arbiter #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input logic              clk,
   input logic              rst_n,
   wb_write_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     count_q;
   logic            rf_we_q;
   logic [4:0]      rf_a3_q;
   logic [XLEN-1:0] rf_wd_q;
   logic            err_q;

   logic            wb_hit, empty, full, lu_keep, push, pop, bypass;
   logic [31:0]     pend;

   always_comb begin
      wb_hit  = bus.wb_we && (bus.wb_rd != 5'd0);
      empty   = (count_q == '0);
      full    = (count_q == FULL_CNT);
      lu_keep = bus.lu_valid && bus.lu_ready && (bus.lu_rd != 5'd0);
      pop     = !wb_hit && !empty;
`ifdef WB_BYPASS_EN
      bypass  = !wb_hit && empty && lu_keep;
`else
      bypass  = 1'b0;
`endif
      push    = lu_keep && !bypass;
   end

   // ready reflects pre-pop occupancy, so a full FIFO never pops through
   assign bus.lu_ready = rst_n && !full;

   always_comb begin
      logic [AW-1:0] idx;
      idx  = '0;
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rptr_q + AW'(i);
         if (i < int'(count_q)) pend[mem_q[idx].rd] = 1'b1;
      end
      if (rf_we_q) pend[rf_a3_q] = 1'b1;
      pend[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{rd: bus.lu_rd, data: bus.lu_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         rf_we_q <= 1'b0;
         rf_a3_q <= '0;
         rf_wd_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (wb_hit) begin
            rf_we_q <= 1'b1;
            rf_a3_q <= bus.wb_rd;
            rf_wd_q <= bus.wb_data;
            if (pend[bus.wb_rd]) err_q <= 1'b1;
         end else if (pop) begin
            rf_we_q <= 1'b1;
            rf_a3_q <= mem_q[rptr_q].rd;
            rf_wd_q <= mem_q[rptr_q].data;
         end else if (bypass) begin
            rf_we_q <= 1'b1;
            rf_a3_q <= bus.lu_rd;
            rf_wd_q <= bus.lu_data;
         end else begin
            rf_we_q <= 1'b0;
         end
      end
   end

   assign bus.rf_we        = rf_we_q;
   assign bus.rf_a3        = rf_a3_q;
   assign bus.rf_wd        = rf_wd_q;
   assign bus.pend_mask    = pend;
   assign bus.err_conflict = err_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, priority, backpressure, x0, conflict, bypass latency.
module tb_wb_write_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_write_arbiter_if #(.XLEN(32)) bus ();

   wb_write_arbiter #(.DEPTH(4), .XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
      bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = d;
   endtask

   task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.lu_valid = v; bus.lu_rd = rd; bus.lu_data = d;
   endtask

   function automatic logic [31:0] oh(input int r);
      return 32'd1 << r;
   endfunction

   task automatic chk_rf(input string tag, input logic we, input logic [4:0] a3, input logic [31:0] wd);
      chk({tag, "_we"}, 64'(bus.rf_we), 64'(we));
      chk({tag, "_a3"}, 64'(bus.rf_a3), 64'(a3));
      chk({tag, "_wd"}, 64'(bus.rf_wd), 64'(wd));
   endtask

   initial begin
      wb(1'b0, 5'd0, 32'h0);
      lu(1'b0, 5'd0, 32'h0);

      // power-on reset
      #2 rst_n = 1'b0;
      #1;
      chk_rf("por", 1'b0, 5'd0, 32'h0);
      chk("por_err",   64'(bus.err_conflict), 64'd0);
      chk("por_ready", 64'(bus.lu_ready),     64'd0);
      chk("por_pend",  64'(bus.pend_mask),    64'd0);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("rel_ready", 64'(bus.lu_ready), 64'd1);

      // priority: WB holds the port, LU x7 waits in the FIFO
      wb(1'b1, 5'd5, 32'h11);
      lu(1'b1, 5'd7, 32'hAA);
      step();
      lu(1'b0, 5'd0, 32'h0);
      chk_rf("pri_wb1", 1'b1, 5'd5, 32'h11);
      chk("pri_pend1", 64'(bus.pend_mask), 64'(oh(7) | oh(5)));
      step();
      chk_rf("pri_wb2", 1'b1, 5'd5, 32'h11);
      chk("pri_pend2", 64'(bus.pend_mask), 64'(oh(7) | oh(5)));
      wb(1'b0, 5'd0, 32'h0);
      step();
      chk_rf("pri_lu", 1'b1, 5'd7, 32'hAA);
      chk("pri_pend3", 64'(bus.pend_mask), 64'(oh(7)));
      step();
      chk_rf("pri_idle", 1'b0, 5'd7, 32'hAA);
      chk("pri_pend4", 64'(bus.pend_mask), 64'd0);

      // zero register from both sources
      wb(1'b1, 5'd0, 32'h33);
      lu(1'b1, 5'd0, 32'h44);
      step();
      chk_rf("x0_a", 1'b0, 5'd7, 32'hAA);
      chk("x0_pend",  64'(bus.pend_mask), 64'd0);
      chk("x0_ready", 64'(bus.lu_ready),  64'd1);
      wb(1'b0, 5'd0, 32'h0);
      lu(1'b0, 5'd0, 32'h0);
      step();
      chk("x0_we2", 64'(bus.rf_we), 64'd0);

      // fill to DEPTH under WB pressure, stall a fifth result
      wb(1'b1, 5'd5, 32'h22);
      for (int k = 1; k <= 4; k++) begin
         lu(1'b1, 5'(k), 32'h100 + 32'(k));
         chk("full_rdy_in", 64'(bus.lu_ready), 64'd1);
         step();
      end
      chk("full_ready", 64'(bus.lu_ready), 64'd0);
      chk("full_pend",  64'(bus.pend_mask), 64'(oh(1) | oh(2) | oh(3) | oh(4) | oh(5)));
      lu(1'b1, 5'd6, 32'h106);
      step();
      chk("stall_rdy1", 64'(bus.lu_ready), 64'd0);
      step();
      chk("stall_rdy2", 64'(bus.lu_ready), 64'd0);
      chk("stall_pend", 64'(bus.pend_mask), 64'(oh(1) | oh(2) | oh(3) | oh(4) | oh(5)));
      wb(1'b0, 5'd0, 32'h0);
      step();
      chk_rf("drain1", 1'b1, 5'd1, 32'h101);
      chk("drain_rdy", 64'(bus.lu_ready), 64'd1);
      step();
      lu(1'b0, 5'd0, 32'h0);
      chk_rf("drain2", 1'b1, 5'd2, 32'h102);
      step();
      chk_rf("drain3", 1'b1, 5'd3, 32'h103);
      step();
      chk_rf("drain4", 1'b1, 5'd4, 32'h104);
      step();
      chk_rf("drain5", 1'b1, 5'd6, 32'h106);
      step();
      chk("drain_idle", 64'(bus.rf_we), 64'd0);
      chk("drain_pend", 64'(bus.pend_mask), 64'd0);

      // reset with three entries queued (repeated WB x5 also sets the sticky flag)
      wb(1'b1, 5'd5, 32'h55);
      for (int k = 1; k <= 3; k++) begin
         lu(1'b1, 5'(k + 10), 32'h200 + 32'(k));
         step();
      end
      chk("mid_err_pre", 64'(bus.err_conflict), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_rf("mid_rst", 1'b0, 5'd0, 32'h0);
      chk("mid_pend",  64'(bus.pend_mask),    64'd0);
      chk("mid_ready", 64'(bus.lu_ready),     64'd0);
      chk("mid_err",   64'(bus.err_conflict), 64'd0);
      wb(1'b0, 5'd0, 32'h0);
      lu(1'b0, 5'd0, 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      chk("mid_rel_ready", 64'(bus.lu_ready), 64'd1);
      step();
      chk("mid_empty1", 64'(bus.rf_we), 64'd0);
      step();
      chk("mid_empty2", 64'(bus.rf_we), 64'd0);
      chk("mid_pend2",  64'(bus.pend_mask), 64'd0);

      // conflict: x9 queued, then WB x9
      wb(1'b1, 5'd5, 32'h5);
      lu(1'b1, 5'd9, 32'h99);
      step();
      lu(1'b0, 5'd0, 32'h0);
      chk("cf_err0", 64'(bus.err_conflict), 64'd0);
      chk("cf_pend", 64'(bus.pend_mask), 64'(oh(9) | oh(5)));
      wb(1'b1, 5'd9, 32'h77);
      step();
      chk_rf("cf_wb", 1'b1, 5'd9, 32'h77);
      chk("cf_err1", 64'(bus.err_conflict), 64'd1);
      wb(1'b0, 5'd0, 32'h0);
      step();
      chk_rf("cf_lu", 1'b1, 5'd9, 32'h99);
      step();
      chk("cf_idle", 64'(bus.rf_we), 64'd0);
      chk("cf_err2", 64'(bus.err_conflict), 64'd1);

      // LU-to-port latency with FIFO empty and WB idle
      lu(1'b1, 5'd3, 32'h55);
      step();
      lu(1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
      chk_rf("byp_1", 1'b1, 5'd3, 32'h55);
      step();
      chk("byp_2", 64'(bus.rf_we), 64'd0);
`else
      chk("byp_1", 64'(bus.rf_we), 64'd0);
      chk("byp_pend", 64'(bus.pend_mask), 64'(oh(3)));
      step();
      chk_rf("byp_2", 1'b1, 5'd3, 32'h55);
`endif
      step();
      chk("byp_idle", 64'(bus.rf_we), 64'd0);
      chk("end_err", 64'(bus.err_conflict), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
